// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequences PC-addressed reads, holds the fetched word for decode, handles branch redirects and HALT.
// Optional wait-state timeout is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_ack,
    input  logic [15:0]       mem_rd_data,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [15:0]       instr_out,
    output logic [5:0]        opcode,
    output logic [9:0]        imm_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              fetch_err
);

    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [5:0]  OP_HALT = 6'h3F;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_VALID, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic [15:0]        instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               req_q, req_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= ADDR_W'(RESET_PC);
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            req_q    <= req_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and next-output logic; a branch always takes priority over ack and stall
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        req_d    = req_q;
        halted_d = halted_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_FETCH: begin
                if (branch_en) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                    req_d   = 1'b0;
                end else begin
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_en) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else if (mem_rd_ack) begin
                    instr_d  = mem_rd_data;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(1);
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_VALID;
                end else if (TIMEOUT_EN) begin
                    // Give up on this attempt and re-issue the same PC from FETCH
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        req_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_VALID: begin
                req_d = 1'b0;
                if (branch_en) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    if (instr_q[15:10] == OP_HALT) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign mem_rd_req  = req_q;
    assign mem_addr    = pc_q;
    assign instr_out   = instr_q;
    assign opcode      = instr_q[15:10];
    assign imm_out     = instr_q[9:0];
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign halted      = halted_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected fetches are queued, a monitor checks each new valid instruction.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_rd_req;
    logic [9:0]  mem_addr;
    logic        mem_rd_ack;
    logic [15:0] mem_rd_data;
    logic        stall;
    logic        branch_en;
    logic [9:0]  branch_target;
    logic [15:0] instr_out;
    logic [5:0]  opcode;
    logic [9:0]  imm_out;
    logic        instr_valid;
    logic [9:0]  pc_out;
    logic        halted;
    logic        fetch_err;

`ifdef FETCH_TIMEOUT_EN
    localparam bit EXP_TO = 1'b1;
`else
    localparam bit EXP_TO = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] instr;
        logic [9:0]  pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem_model [0:1023];
    logic        auto_ack;
    logic        force_ack;
    logic        prev_valid;
    int          n_cmp;
    int          n_err;

    instruction_fetch_unit #(.ADDR_W(10), .RESET_PC(0), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_rd_req    (mem_rd_req),
        .mem_addr      (mem_addr),
        .mem_rd_ack    (mem_rd_ack),
        .mem_rd_data   (mem_rd_data),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .instr_out     (instr_out),
        .opcode        (opcode),
        .imm_out       (imm_out),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .halted        (halted),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        tick();
        while (instr_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(name, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        tick();
        while (mem_rd_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(name, 32'(mem_rd_req), 32'd1);
    endtask

    // Memory responder: same-cycle ack, driven away from the active edge
    always @(negedge clk) begin
        mem_rd_ack  = force_ack | (auto_ack & mem_rd_req);
        mem_rd_data = force_ack ? 16'hDEAD : mem_model[mem_addr];
    end

    // Monitor: every rising instr_valid must match the oldest queued expectation
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", 32'(instr_out), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", 32'(instr_out), 32'(e.instr));
                check("sb_pc", 32'(pc_out), 32'(e.pc));
                check("sb_opcode", 32'(opcode), 32'(e.instr[15:10]));
                check("sb_imm", 32'(imm_out), 32'(e.instr[9:0]));
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        stall = 1'b0;
        branch_en = 1'b0;
        branch_target = '0;
        auto_ack = 1'b1;
        force_ack = 1'b0;
        prev_valid = 1'b0;
        mem_rd_ack = 1'b0;
        mem_rd_data = '0;
        for (int i = 0; i < 1024; i++) mem_model[i] = 16'h0405;
        mem_model[2]     = 16'hABCD;
        mem_model[10'h120] = 16'h1234;
        mem_model[10'h3FF] = 16'h0ABC;

        // Reset state
        tick(); tick(); tick();
        check("rst_instr", 32'(instr_out), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_req", 32'(mem_rd_req), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_err", 32'(fetch_err), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);

        // First fetch: request on 1st edge after release, valid on the next (3rd counting the reset edge)
        rst_n = 1'b1;
        exp_q.push_back('{instr: 16'h0405, pc: 10'h000});
        tick();
        check("first_req", 32'(mem_rd_req), 32'h1);
        check("first_valid_early", 32'(instr_valid), 32'h0);
        tick();
        check("first_valid", 32'(instr_valid), 32'h1);
        check("first_next_addr", 32'(mem_addr), 32'h1);

        // Stall holds VALID with outputs stable and no request
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_instr", 32'(instr_out), 32'h0405);
            check("stall_pc", 32'(pc_out), 32'h0);
            check("stall_valid", 32'(instr_valid), 32'h1);
            check("stall_req", 32'(mem_rd_req), 32'h0);
        end
        stall = 1'b0;
        exp_q.push_back('{instr: 16'h0405, pc: 10'h001});
        wait_valid("wait_pc1");

        // Branch coincident with ack: data discarded, redirect to 0x120
        wait_req("wait_req_pc2");
        check("pc2_addr", 32'(mem_addr), 32'h2);
        branch_en = 1'b1;
        branch_target = 10'h120;
        tick();
        branch_en = 1'b0;
        check("br_ack_instr", 32'(instr_out), 32'h0405);
        check("br_ack_valid", 32'(instr_valid), 32'h0);
        check("br_ack_addr", 32'(mem_addr), 32'h120);
        check("br_ack_pcout", 32'(pc_out), 32'h1);
        exp_q.push_back('{instr: 16'h1234, pc: 10'h120});
        wait_valid("wait_pc120");

        // Branch beats stall in VALID
        stall = 1'b1;
        branch_en = 1'b1;
        branch_target = 10'h3FF;
        tick();
        stall = 1'b0;
        branch_en = 1'b0;
        check("br_stall_valid", 32'(instr_valid), 32'h0);
        check("br_stall_addr", 32'(mem_addr), 32'h3FF);
        check("br_stall_instr", 32'(instr_out), 32'h1234);

        // PC wrap from all-ones
        exp_q.push_back('{instr: 16'h0ABC, pc: 10'h3FF});
        wait_valid("wait_pc3ff");
        check("wrap_pcout", 32'(pc_out), 32'h3FF);
        check("wrap_addr", 32'(mem_addr), 32'h0);

        // No ack: timeout re-issue with the feature, indefinite wait without it
        auto_ack = 1'b0;
        wait_req("wait_req_noack");
        if (EXP_TO) begin
            for (int i = 1; i <= 14; i++) begin
                tick();
                check("to_wait_req", 32'(mem_rd_req), 32'h1);
                check("to_wait_err", 32'(fetch_err), 32'h0);
            end
            tick();
            check("to_fire_err", 32'(fetch_err), 32'h1);
            check("to_fire_req", 32'(mem_rd_req), 32'h0);
            tick();
            check("to_reissue_req", 32'(mem_rd_req), 32'h1);
            check("to_reissue_addr", 32'(mem_addr), 32'h0);
        end else begin
            for (int i = 1; i <= 20; i++) begin
                tick();
                check("nto_req", 32'(mem_rd_req), 32'h1);
                check("nto_err", 32'(fetch_err), 32'h0);
                check("nto_addr", 32'(mem_addr), 32'h0);
            end
        end

        // HALT opcode: halts after VALID, ignores branches, cleared by reset
        mem_model[0] = 16'hFC00;
        auto_ack = 1'b1;
        exp_q.push_back('{instr: 16'hFC00, pc: 10'h000});
        wait_valid("wait_halt_instr");
        tick();
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_valid", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            branch_en = 1'b1;
            branch_target = 10'h055;
            tick();
            check("halt_req", 32'(mem_rd_req), 32'h0);
            check("halt_stay", 32'(halted), 32'h1);
            check("halt_addr", 32'(mem_addr), 32'h1);
        end
        branch_en = 1'b0;
        check("halt_err_sticky", 32'(fetch_err), 32'(EXP_TO));
        rst_n = 1'b0;
        tick();
        check("halt_rst_halted", 32'(halted), 32'h0);
        check("halt_rst_addr", 32'(mem_addr), 32'h0);
        check("halt_rst_instr", 32'(instr_out), 32'h0);
        check("halt_rst_err", 32'(fetch_err), 32'h0);

        // Reset mid-WAIT abandons the request; a stray ack in FETCH is ignored
        rst_n = 1'b1;
        auto_ack = 1'b0;
        wait_req("wait_req_midrst");
        rst_n = 1'b0;
        tick();
        check("midrst_req", 32'(mem_rd_req), 32'h0);
        rst_n = 1'b1;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check("stray_ack_valid", 32'(instr_valid), 32'h0);
        check("stray_ack_instr", 32'(instr_out), 32'h0);
        mem_model[0] = 16'h0C21;
        auto_ack = 1'b1;
        exp_q.push_back('{instr: 16'h0C21, pc: 10'h000});
        wait_valid("wait_after_midrst");

        tick(); tick();
        check("sb_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
